// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the command-master state enumeration.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RESP
    } state_t;

    // A command is legal when its size is defined and the address is naturally aligned.
    function automatic logic cmd_legal(input logic [1:0] size, input logic [1:0] addr_lsb);
        case (size)
            2'b00:   cmd_legal = 1'b1;
            2'b01:   cmd_legal = ~addr_lsb[0];
            2'b10:   cmd_legal = (addr_lsb == 2'b00);
            default: cmd_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_cmd_master.sv
// Single-transfer AHB-Lite master driven by a valid/ready command port.
// Optional data-phase timeout abort: define AHB_CMD_MASTER_TIMEOUT_EN.
module ahb_cmd_master
    import ahb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        AHB_HCLK,
    input  logic        AHB_HRESETn,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [1:0]  cmd_size,
    input  logic [31:0] cmd_wdata,

    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        rsp_timeout,

    output logic [31:0] AHB_HADDR,
    output logic [1:0]  AHB_HTRANS,
    output logic        AHB_HWRITE,
    output logic [2:0]  AHB_HSIZE,
    output logic [2:0]  AHB_HBURST,
    output logic [3:0]  AHB_HPROT,
    output logic        AHB_HMASTLOCK,
    output logic [31:0] AHB_HWDATA,
    input  logic [31:0] AHB_HRDATA,
    input  logic        AHB_HREADY,
    input  logic [1:0]  AHB_HRESP
);

    state_t      state_q, state_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;

    logic        cmd_ready_q, cmd_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;

    logic [1:0]  htrans_q, htrans_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [3:0]  hprot_q;

    logic        unused_hresp;
    assign unused_hresp = AHB_HRESP[1];

`ifdef AHB_CMD_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             rsp_timeout_q, rsp_timeout_d;
`else
    logic unused_cfg;
    assign unused_cfg = (TIMEOUT_CYCLES == 0);
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d     = state_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        htrans_d    = HTRANS_IDLE;
        haddr_d     = '0;
        hwrite_d    = 1'b0;
        hsize_d     = '0;
        hwdata_d    = '0;
`ifdef AHB_CMD_MASTER_TIMEOUT_EN
        wait_cnt_d    = '0;
        rsp_timeout_d = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (cmd_legal(cmd_size, cmd_addr[1:0])) begin
                        wr_d    = cmd_write;
                        addr_d  = cmd_addr;
                        size_d  = cmd_size;
                        wdata_d = cmd_wdata;
                        state_d = ST_ADDR;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_ADDR: begin
                if (AHB_HREADY) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (AHB_HREADY) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = AHB_HRESP[0];
                    rsp_rdata_d = (!wr_q && !AHB_HRESP[0]) ? AHB_HRDATA : 32'h0;
                    state_d     = ST_RESP;
                end
`ifdef AHB_CMD_MASTER_TIMEOUT_EN
                else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`endif
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Bus outputs are derived from the next state so they appear registered in that state.
        case (state_d)
            ST_ADDR: begin
                htrans_d = HTRANS_NONSEQ;
                haddr_d  = addr_d;
                hwrite_d = wr_d;
                hsize_d  = {1'b0, size_d};
            end
            ST_DATA: hwdata_d = wr_d ? wdata_d : 32'h0;
            default: ;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
        if (!AHB_HRESETn) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            cmd_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            hwdata_q    <= '0;
            hprot_q     <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hwdata_q    <= hwdata_d;
            hprot_q     <= HPROT_DEFAULT;
        end
    end

`ifdef AHB_CMD_MASTER_TIMEOUT_EN
    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
        if (!AHB_HRESETn) begin
            wait_cnt_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end
    assign rsp_timeout = rsp_timeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign AHB_HTRANS    = htrans_q;
    assign AHB_HADDR     = haddr_q;
    assign AHB_HWRITE    = hwrite_q;
    assign AHB_HSIZE     = hsize_q;
    assign AHB_HWDATA    = hwdata_q;
    assign AHB_HPROT     = hprot_q;
    assign AHB_HBURST    = HBURST_SINGLE;
    assign AHB_HMASTLOCK = 1'b0;

endmodule

// File: doc/ahb_cmd_master.md
AHB_CMD_MASTER -- requirements
Module: ahb_cmd_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256, maximum number of HREADY-low data-phase cycles before abort.
REQ-002 AHB_HCLK  in  1  clock; AHB_HRESETn  in  1  reset, asynchronous, active-low.
REQ-003 cmd_valid  in  1  command request.
REQ-004 cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
REQ-005 cmd_write  in  1  1=write, 0=read.
REQ-006 cmd_addr  in  32  byte address.
REQ-007 cmd_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
REQ-008 cmd_wdata  in  32  write data.
REQ-009 rsp_valid  out  1  one-cycle response pulse.
REQ-010 rsp_rdata  out  32  read data, valid with rsp_valid.
REQ-011 rsp_err  out  1  bus error, misalignment or timeout.
REQ-012 rsp_timeout  out  1  abort due to timeout.
REQ-013 AHB_HADDR out 32, AHB_HTRANS out 2, AHB_HWRITE out 1, AHB_HSIZE out 3, AHB_HBURST out 3, AHB_HPROT out 4, AHB_HMASTLOCK out 1, AHB_HWDATA out 32: AHB-Lite master outputs.
REQ-014 AHB_HRDATA in 32, AHB_HREADY in 1, AHB_HRESP in 2: AHB-Lite slave returns; HRESP[0]=ERROR.

Function
REQ-015 States: IDLE, ADDR, DATA, RESP; all outputs registered.
REQ-016 cmd_ready SHALL be 1 only in IDLE.
REQ-017 IDLE: on accept with legal size and aligned address, latch command and go to ADDR next cycle.
REQ-018 Illegal size (11), or misalignment (half: addr[0]=1; word: addr[1:0]!=0), SHALL go to RESP with rsp_err=1 and no bus transfer.
REQ-019 ADDR: drive HTRANS=NONSEQ(10), HADDR, HWRITE, HSIZE={0,cmd_size}; go to DATA on the first cycle with HREADY=1; otherwise hold all signals.
REQ-020 DATA: HTRANS=IDLE(00); for writes, HWDATA=latched data, held until HREADY=1.
REQ-021 DATA exit on HREADY=1: capture HRDATA (reads) and HRESP[0] into rsp_err; go to RESP.
REQ-022 ERROR response (HRESP=01 with HREADY=0 then HREADY=1) SHALL end in rsp_err=1; HTRANS is already IDLE, so no further transfer is issued.
REQ-023 RESP: rsp_valid=1 for exactly one cycle, then IDLE; rsp_rdata SHALL be 0 for writes and errors.
REQ-024 Zero-wait latency: accept at cycle N, ADDR at N+1, DATA at N+2, rsp_valid at N+3; each HREADY-low cycle adds one.
REQ-025 Fixed outputs: HBURST=000 (SINGLE), HPROT=0011, HMASTLOCK=0.
REQ-026 cmd_* SHALL be ignored outside IDLE; at most one transfer in flight.

Reset
REQ-027 Reset SHALL force IDLE with all bus outputs 0 (HTRANS=IDLE), cmd_ready=0 during reset and 1 from the first cycle after release, and rsp_valid, rsp_err, rsp_timeout and rsp_rdata all 0.
REQ-028 Reset mid-transfer SHALL abandon the transfer with no response pulse.

Configuration
REQ-029 With AHB_CMD_MASTER_TIMEOUT_EN defined, a counter SHALL count consecutive HREADY-low cycles in DATA.
REQ-030 With the macro defined, on reaching TIMEOUT_CYCLES the block SHALL go to RESP with rsp_err=1 and rsp_timeout=1.
REQ-031 Without the macro, DATA SHALL wait indefinitely, and rsp_timeout SHALL be constant 0.

Structure
REQ-032 Package ahb_pkg SHALL hold the HTRANS codes (IDLE, NONSEQ), HSIZE codes, HBURST_SINGLE, HPROT default, HRESP_OKAY/ERROR and the state enumeration.
REQ-033 No sub-module is needed; the timeout counter stays inline under the macro.

Verification
REQ-034 Word write 0x0000_0008 = 0x0000_0001 with HREADY held 1 -> NONSEQ at N+1, HWDATA 0x1 at N+2, rsp_valid at N+3 with rsp_err=0.
REQ-035 Word read 0x000C with 3 HREADY-low data cycles, HRDATA=0x0000_00A5 -> rsp_valid at N+6 with rsp_rdata=0xA5.
REQ-036 Two-cycle ERROR response on read 0x0010 -> rsp_err=1, rsp_rdata=0, HTRANS stays IDLE.
REQ-037 Half-word command at address 0x0003 -> rsp_err=1 at N+1, HTRANS never NONSEQ.
REQ-038 Macro defined, TIMEOUT_CYCLES=4, HREADY held 0 -> rsp_timeout=1 and rsp_err=1 after 4 DATA cycles; macro undefined -> no response.
REQ-039 Reset asserted in DATA -> all outputs 0, no rsp_valid; cmd_ready=1 on the first cycle after release.
